// File: rtl/mic_tone_qualifier.sv
// Per-microphone front end: synchronizes and deglitches the comparator output,
// measures the rising-edge period and qualifies a steady in-window tone.
module mic_tone_qualifier #(
  parameter int SYNC_STAGES   = 2,
  parameter int GLITCH_CYCLES = 16,
  parameter int CNT_WIDTH     = 17,
  parameter int MIN_PERIOD    = 60000,
  parameter int MAX_PERIOD    = 73333,
  parameter int LOCK_COUNT    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 mic_raw,
  output logic                 mic_clean,
  output logic                 rise_pulse,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
  output logic                 tone_locked
);

  localparam int GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] SAT_P  = CNT_WIDTH'(MAX_PERIOD + 1);
  localparam logic [CNT_WIDTH-1:0] MIN_P  = CNT_WIDTH'(MIN_PERIOD);
  localparam logic [CNT_WIDTH-1:0] MAX_P  = CNT_WIDTH'(MAX_PERIOD);
  localparam logic [GW-1:0]        G_LAST = GW'(GLITCH_CYCLES - 1);
  localparam logic [LW-1:0]        L_LAST = LW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
  logic                   sync_q;
  logic [GW-1:0]          glitch_cnt_q, glitch_cnt_d;
  logic                   mic_clean_q, mic_clean_d;
  logic                   rise_pulse_q, rise_pulse_d;
  logic [CNT_WIDTH-1:0]   per_cnt_q, per_cnt_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  logic                   period_valid_q, period_valid_d;
  logic                   first_seen_q, first_seen_d;
  logic [LW-1:0]          good_cnt_q, good_cnt_d;
  state_t                 state_q, state_d;
  logic                   tone_locked_q, tone_locked_d;
  logic                   in_win;
  logic                   timeout;

  assign sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], mic_raw};
  assign sync_q       = sync_chain_q[SYNC_STAGES-1];

  // A new level must survive GLITCH_CYCLES consecutive samples before it is accepted.
  always_comb begin
    glitch_cnt_d = '0;
    mic_clean_d  = mic_clean_q;
    if (sync_q != mic_clean_q) begin
      if (glitch_cnt_q == G_LAST) begin
        mic_clean_d = sync_q;
      end else begin
        glitch_cnt_d = glitch_cnt_q + 1'b1;
      end
    end
  end

  assign rise_pulse_d = enable & mic_clean_d & ~mic_clean_q;

  always_comb begin
    state_d        = state_q;
    good_cnt_d     = good_cnt_q;
    first_seen_d   = first_seen_q;
    per_cnt_d      = per_cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    in_win         = (period_q >= MIN_P) && (period_q <= MAX_P);
    timeout        = (state_q != IDLE) && !rise_pulse_q && (per_cnt_q == SAT_P);

    if (rise_pulse_q) begin
      per_cnt_d    = CNT_WIDTH'(1);
      first_seen_d = 1'b1;
    end else if (per_cnt_q < SAT_P) begin
      per_cnt_d = per_cnt_q + 1'b1;
    end

    // The first edge after arming only starts the measurement.
    if (rise_pulse_q && first_seen_q) begin
      period_d       = per_cnt_q;
      period_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (rise_pulse_q) begin
          state_d    = ACQUIRE;
          good_cnt_d = '0;
        end
      end
      ACQUIRE: begin
        if (period_valid_q) begin
          if (in_win) begin
            good_cnt_d = good_cnt_q + 1'b1;
            if (good_cnt_q == L_LAST) state_d = LOCKED;
          end else begin
            good_cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        if (period_valid_q && !in_win) begin
          state_d    = ACQUIRE;
          good_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d      = IDLE;
      first_seen_d = 1'b0;
      good_cnt_d   = '0;
    end

    // Disable overrides everything except the deglitched level and the held period.
    if (!enable) begin
      state_d        = IDLE;
      first_seen_d   = 1'b0;
      good_cnt_d     = '0;
      per_cnt_d      = '0;
      period_d       = period_q;
      period_valid_d = 1'b0;
    end
  end

  assign tone_locked_d = (state_d == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_chain_q   <= '0;
      glitch_cnt_q   <= '0;
      mic_clean_q    <= 1'b0;
      rise_pulse_q   <= 1'b0;
      per_cnt_q      <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      first_seen_q   <= 1'b0;
      good_cnt_q     <= '0;
      state_q        <= IDLE;
      tone_locked_q  <= 1'b0;
    end else begin
      sync_chain_q   <= sync_chain_d;
      glitch_cnt_q   <= glitch_cnt_d;
      mic_clean_q    <= mic_clean_d;
      rise_pulse_q   <= rise_pulse_d;
      per_cnt_q      <= per_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      first_seen_q   <= first_seen_d;
      good_cnt_q     <= good_cnt_d;
      state_q        <= state_d;
      tone_locked_q  <= tone_locked_d;
    end
  end

  assign mic_clean    = mic_clean_q;
  assign rise_pulse   = rise_pulse_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign tone_locked  = tone_locked_q;

endmodule

// File: tb/tb_mic_tone_qualifier.sv
// Bench for mic_tone_qualifier with the period window scaled down (nominal period 333 cycles)
// so every scenario fits in a short run; a cycle-level model is compared every clock.
module tb_mic_tone_qualifier;
  localparam int SS   = 2;
  localparam int GC   = 16;
  localparam int CW   = 9;
  localparam int MINP = 300;
  localparam int MAXP = 366;
  localparam int LC   = 4;
  localparam int HL   = SS + GC;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic mic_raw = 1'b0;
  logic mic_clean, rise_pulse, period_valid, tone_locked;
  logic [CW-1:0] period;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mic_tone_qualifier #(
    .SYNC_STAGES(SS), .GLITCH_CYCLES(GC), .CNT_WIDTH(CW),
    .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP), .LOCK_COUNT(LC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mic_raw(mic_raw),
    .mic_clean(mic_clean), .rise_pulse(rise_pulse), .period(period),
    .period_valid(period_valid), .tone_locked(tone_locked)
  );

  // Model state after each clock edge; edges are numbered, rises are timestamped.
  bit h [HL];
  bit m_clean, m_rise, m_pv, m_lock, m_armed;
  int m_period, m_good, m_last_rise, m_edge;
  bit o_clean, o_rise, o_pv, flip;
  int o_period, delta;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < HL; i++) h[i] = 1'b0;
        m_clean = 0; m_rise = 0; m_pv = 0; m_lock = 0; m_armed = 0;
        m_period = 0; m_good = 0; m_last_rise = 0; m_edge = 0;
      end else begin
        o_clean = m_clean; o_rise = m_rise; o_pv = m_pv; o_period = m_period;
        m_edge++;
        for (int i = HL - 1; i > 0; i--) h[i] = h[i-1];
        h[0] = mic_raw;
        // Level accepted once the synchronized input has differed for GC straight cycles.
        flip = 1'b1;
        for (int i = SS; i < SS + GC; i++) if (h[i] == o_clean) flip = 1'b0;
        if (flip) m_clean = !o_clean;
        m_rise = enable && m_clean && !o_clean;
        m_pv = 1'b0;
        if (!enable) begin
          m_armed = 0; m_lock = 0; m_good = 0;
        end else begin
          if (o_pv) begin
            if (o_period >= MINP && o_period <= MAXP) begin
              if (!m_lock) begin
                m_good++;
                if (m_good == LC) m_lock = 1;
              end
            end else begin
              m_good = 0; m_lock = 0;
            end
          end
          delta = (m_edge - 1) - m_last_rise;
          if (o_rise) begin
            if (m_armed) begin
              m_pv = 1'b1;
              m_period = (delta > MAXP + 1) ? MAXP + 1 : delta;
            end else begin
              m_armed = 1; m_good = 0;
            end
            m_last_rise = m_edge - 1;
          end else if (m_armed && delta == MAXP + 1) begin
            m_armed = 0; m_lock = 0; m_good = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if ({mic_clean, rise_pulse, period_valid, tone_locked} !== {m_clean, m_rise, m_pv, m_lock} ||
          period !== CW'(m_period)) begin
        errors++;
        $display("FAIL model t=%0t: clean/rise/pv/lock=%b%b%b%b period=%0d, required %b%b%b%b period=%0d",
                 $time, mic_clean, rise_pulse, period_valid, tone_locked, period,
                 m_clean, m_rise, m_pv, m_lock, m_period);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic half(input bit lvl, input int len, input int glitch);
    mic_raw = lvl;
    if (glitch > 0) begin
      cyc(len / 2);
      mic_raw = !lvl;
      cyc(glitch);
      mic_raw = lvl;
      cyc(len - len / 2 - glitch);
    end else begin
      cyc(len);
    end
  endtask

  task automatic tone(input int hi, input int lo, input int n, input int glitch);
    for (int p = 0; p < n; p++) begin
      half(1'b1, hi, glitch);
      half(1'b0, lo, glitch);
    end
  endtask

  task automatic lit(input string name, input int exp_per, input bit exp_lock);
    checks++;
    if (period !== CW'(exp_per) || tone_locked !== exp_lock || m_period != exp_per || m_lock != exp_lock) begin
      errors++;
      $display("FAIL %s: dut period=%0d locked=%b model period=%0d locked=%b, required period=%0d locked=%b",
               name, period, tone_locked, m_period, m_lock, exp_per, exp_lock);
    end else begin
      $display("ok   %s: period=%0d locked=%b", name, period, tone_locked);
    end
  endtask

  task automatic rst_lit(input string name);
    checks++;
    if ({mic_clean, rise_pulse, period_valid, tone_locked} !== 4'b0000 || period !== '0) begin
      errors++;
      $display("FAIL %s: clean/rise/pv/lock=%b%b%b%b period=%0d, required 0000 period=0",
               name, mic_clean, rise_pulse, period_valid, tone_locked, period);
    end else begin
      $display("ok   %s: all outputs zero", name);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cyc(3);
    rst_lit("reset_state");
    #2 rst_n = 1'b1;
    enable = 1'b1;
    cyc(5);
    lit("idle_after_reset", 0, 0);

    tone(167, 166, 8, 0);
    lit("tone_1500_lock", 333, 1);

    tone(167, 166, 6, 10);
    lit("glitched_tone_holds_lock", 333, 1);

    tone(125, 125, 1, 0);
    tone(167, 166, 1, 0);
    lit("short_period_drops_lock", 250, 0);
    tone(167, 166, 4, 0);
    lit("relock_after_4_good", 333, 1);

    mic_raw = 1'b0;
    cyc(450);
    lit("timeout_no_edges", 333, 0);

    tone(250, 250, 4, 0);
    lit("slow_tone_never_locks", 333, 0);

    tone(167, 166, 6, 0);
    lit("lock_before_disable", 333, 1);
    enable = 1'b0;
    tone(167, 166, 6, 0);
    lit("disabled_no_lock", 333, 0);

    #2 rst_n = 1'b0;
    #1 rst_lit("async_reset_mid_cycle");
    cyc(3);
    #2 rst_n = 1'b1;
    enable = 1'b1;
    tone(167, 166, 4, 0);
    lit("four_edges_after_reset", 333, 0);
    tone(167, 166, 2, 0);
    lit("fifth_edge_relocks", 333, 1);

    cyc(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mic_tone_qualifier.md
Name: mic_tone_qualifier

Overview:
- Per-microphone front end that sits directly upstream of the sound-direction finder; one instance per channel (left, right).
- Takes the raw asynchronous comparator output of one microphone and synchronizes and deglitches it. Drives the clean square wave into the finder's LMic/RMic input.
- Measures the rising-edge period and asserts tone_locked only while the signal is a steady tone inside the 1500 Hz window (period 66,667 cycles at the 100 MHz clk).

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on mic_raw (minimum 2).
- GLITCH_CYCLES, 16, consecutive cycles a new level must persist before mic_clean follows it.
- CNT_WIDTH, 17, width of the period counter and the period output.
- MIN_PERIOD, 60000, smallest in-window period in clk cycles (inclusive).
- MAX_PERIOD, 73333, largest in-window period in clk cycles (inclusive); must be less than 2^CNT_WIDTH-1.
- LOCK_COUNT, 4, consecutive in-window periods required to lock.

Ports:
- clk, input, 1, system clock, 100 MHz.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, qualifier enable; same signal that feeds the finder.
- mic_raw, input, 1, raw comparator output, asynchronous to clk.
- mic_clean, output, 1, synchronized, deglitched mic level (registered).
- rise_pulse, output, 1, one-cycle strobe on each mic_clean 0->1 edge.
- period, output, CNT_WIDTH, last measured rising-edge-to-rising-edge period in cycles.
- period_valid, output, 1, one-cycle strobe when period is updated.
- tone_locked, output, 1, high while the tone is qualified.

Behaviour:
- Reset: single clock; rst_n is asynchronous active-low. Assertion clears every flop immediately. All outputs reset to 0, the FSM to IDLE, and all counters to 0.
- Synchronizer: SYNC_STAGES-flop chain on mic_raw; its last stage is sync_q.
- Glitch filter:
  - glitch_cnt increments each cycle that sync_q != mic_clean and clears whenever they are equal.
  - When sync_q != mic_clean with glitch_cnt == GLITCH_CYCLES-1, mic_clean takes sync_q on that edge and glitch_cnt clears.
  - Latency from a clean mic_raw edge to the mic_clean edge is SYNC_STAGES+GLITCH_CYCLES cycles, ±1 for sampling.
  - Any pulse shorter than GLITCH_CYCLES cycles never reaches mic_clean.
- rise_pulse: registered, high for exactly the first cycle in which mic_clean == 1 after being 0.
- Period counter:
  - per_cnt saturates at MAX_PERIOD+1.
  - In a rise_pulse cycle, per_cnt loads 1; otherwise it increments while below MAX_PERIOD+1.
  - Two rise_pulses N cycles apart therefore see per_cnt == N at the second pulse.
- Period capture:
  - On a rise_pulse with first_seen == 1, period <= per_cnt and period_valid pulses in the next cycle.
  - first_seen sets on the first rise_pulse after reset, enable rising, or entry to IDLE; no period is reported for that first edge.
  - A saturated value (MAX_PERIOD+1) is reported as-is and counts as out-of-window.
- Window test: in_win = (MIN_PERIOD <= period <= MAX_PERIOD), evaluated in the period_valid cycle.
- Lock FSM, states IDLE / ACQUIRE / LOCKED; good_cnt is a counter 0..LOCK_COUNT:
  - IDLE: first_seen = 0. Go to ACQUIRE with good_cnt = 0 on rise_pulse.
  - ACQUIRE: on period_valid with in_win, good_cnt++; when good_cnt reaches LOCK_COUNT, go to LOCKED. On period_valid without in_win, good_cnt <= 0.
  - LOCKED: on period_valid without in_win, go to ACQUIRE with good_cnt = 0.
  - Timeout: in ACQUIRE or LOCKED, per_cnt reaching MAX_PERIOD+1 (no edge) sends the FSM to IDLE and clears first_seen.
- tone_locked: registered, equal to (state == LOCKED), so it rises one cycle after the locking period_valid.
- enable low:
  - The synchronizer and glitch filter keep running, so mic_clean stays valid.
  - The FSM is forced to IDLE; first_seen, good_cnt and per_cnt clear.
  - rise_pulse, period_valid and tone_locked are forced to 0; period holds.
  - Re-enabling starts acquisition from scratch.
- Simultaneous events: timeout and rise_pulse cannot coincide, because a rise_pulse reloads per_cnt. If enable falls in the same cycle as a rise_pulse, enable wins.
- Reset mid-lock: tone_locked drops asynchronously; re-acquisition needs 1+LOCK_COUNT rising edges.

Test Plan:
- 1500 Hz square wave (half period 33,333 cycles) -> period == 66,666 or 66,667 on each period_valid. tone_locked rises one cycle after the 4th period_valid, i.e. after the 5th rise_pulse.
- 1500 Hz tone with 10-cycle glitches of the opposite level injected mid-half-cycle -> mic_clean shows no glitch, period is unchanged, tone_locked stays high.
- 1000 Hz tone (period 100,000) -> per_cnt saturates at 73,334 and the FSM times out to IDLE. tone_locked stays 0; no period_valid carries a value below 73,334.
- Locked 1500 Hz tone, then mic_raw held constant -> tone_locked falls 73,334 cycles (±GLITCH_CYCLES+SYNC_STAGES) after the last rise_pulse.
- Locked, then one period of 50,000 cycles -> tone_locked drops one cycle after that period_valid. It relocks after 4 further good periods.
- Locked, then enable low for 1,000,000 ns followed by rst_n pulsed low mid-cycle -> all outputs 0 immediately on reset. mic_clean resumes tracking after reset; lock is regained only after 5 rising edges.
